// File: rtl/data_store_buffer_pkg.sv
// data_store_buffer_pkg: bus widths, buffer depth, FSM encoding and store entry layout
package data_store_buffer_pkg;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int STRB_W   = 4;
  localparam int SIZE_W   = 2;
  localparam int SB_DEPTH = 4;
  localparam int ENTRY_W  = ADDR_W + DATA_W + STRB_W + SIZE_W;
  typedef enum logic [1:0] {IDLE, W_REQ, W_WAIT, R_WAIT} sb_state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic [SIZE_W-1:0] size;
  } sb_entry_t;
endpackage

// File: rtl/data_store_buffer_sb_fifo.sv
// sb_fifo: DEPTH-entry store queue with wrapping pointers and occupancy count
module sb_fifo import data_store_buffer_pkg::*; #(
  parameter int DEPTH = SB_DEPTH,
  parameter int W     = ENTRY_W
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] ram [DEPTH];
  logic [AW-1:0] wp, rp;
  // entry storage needs no reset; only pointers and count carry state
  always_ff @(posedge aclk)
    if (push) ram[wp] <= din;
  // pointers wrap naturally at a power-of-two depth; push+pop leaves count unchanged
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  assign dout  = ram[rp];
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/data_store_buffer.sv
// data_store_buffer: posts stores into a FIFO and drains them ahead of pass-through loads
module data_store_buffer import data_store_buffer_pkg::*; #(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [SIZE_W-1:0] cpu_size,
  input  logic [STRB_W-1:0] cpu_wstrb,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_addr_ok,
  output logic              cpu_data_ok,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [SIZE_W-1:0] mem_size,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CW = $clog2(DEPTH) + 1;
  sb_state_t state, state_nxt;
  sb_entry_t head, entry_in;
  logic [CW-1:0] count;
  logic full, empty, push, pop, ack_q, load_win, rd_done;
  assign entry_in = '{addr: cpu_addr, wdata: cpu_wdata, wstrb: cpu_wstrb, size: cpu_size};
  sb_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (push),
    .pop     (pop),
    .din     (entry_in),
    .dout    (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );
  // acceptance, acknowledgement and memory-side mux; reset gates the combinational handshakes
  always_comb begin
    load_win    = state == IDLE && empty && !ack_q && !cpu_wr;
    rd_done     = state == R_WAIT && mem_data_ok;
    push        = aresetn && cpu_req && cpu_wr && !full && state != R_WAIT;
    pop         = state == W_WAIT && mem_data_ok;
    cpu_addr_ok = push || (aresetn && load_win && cpu_req && mem_addr_ok);
    cpu_data_ok = ack_q || rd_done;
    cpu_rdata   = rd_done ? mem_rdata : '0;
    mem_req     = state == W_REQ || (aresetn && load_win && cpu_req);
    mem_wr      = state == W_REQ;
    mem_size    = load_win ? cpu_size  : head.size;
    mem_wstrb   = load_win ? cpu_wstrb : head.wstrb;
    mem_addr    = load_win ? cpu_addr  : head.addr;
    mem_wdata   = load_win ? cpu_wdata : head.wdata;
  end
  // draining buffered stores takes priority over starting a load
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   state_nxt = count != '0 ? W_REQ : (load_win && cpu_req && mem_addr_ok) ? R_WAIT : IDLE;
      W_REQ:  state_nxt = mem_addr_ok ? W_WAIT : W_REQ;
      W_WAIT: state_nxt = mem_data_ok ? IDLE : W_WAIT;
      R_WAIT: state_nxt = mem_data_ok ? IDLE : R_WAIT;
    endcase
  end
  // state register and the one-cycle store acknowledgement
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state <= IDLE;
      ack_q <= 1'b0;
    end else begin
      state <= state_nxt;
      ack_q <= push;
    end
endmodule

// File: tb/tb_data_store_buffer.sv
// tb_data_store_buffer: randomized stimulus, memory responder and scoreboard for data_store_buffer
module tb_data_store_buffer;
  localparam int DEPTH = 4;
  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  size;
  } txn_t;
  logic aclk = 1'b0, aresetn = 1'b0;
  logic cpu_req = 1'b0, cpu_wr = 1'b0;
  logic [1:0] cpu_size = '0;
  logic [3:0] cpu_wstrb = '0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic cpu_addr_ok, cpu_data_ok;
  logic [31:0] cpu_rdata;
  logic mem_req, mem_wr;
  logic [1:0] mem_size;
  logic [3:0] mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = '0;
  int checks = 0, errors = 0;
  int p_aok = 100, lat_lo = 0, lat_hi = 3;
  txn_t exp_mem[$];
  logic [31:0] rd_exp[$];
  int mcount = 0;
  bit ack_pend = 0, rd_pend = 0, out_busy = 0, out_wr = 0, prev_wait = 0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;

  always #5 aclk = ~aclk;

  data_store_buffer #(.DEPTH(DEPTH)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .cpu_req     (cpu_req),
    .cpu_wr      (cpu_wr),
    .cpu_size    (cpu_size),
    .cpu_wstrb   (cpu_wstrb),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_addr_ok (cpu_addr_ok),
    .cpu_data_ok (cpu_data_ok),
    .cpu_rdata   (cpu_rdata),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_size    (mem_size),
    .mem_wstrb   (mem_wstrb),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_addr_ok (mem_addr_ok),
    .mem_data_ok (mem_data_ok),
    .mem_rdata   (mem_rdata)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic req(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] strb, input logic [1:0] size);
    int n;
    @(posedge aclk); #1;
    cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_wdata = data; cpu_wstrb = strb; cpu_size = size;
    n = 0;
    @(negedge aclk);
    while (!cpu_addr_ok && n < 400) begin
      @(negedge aclk);
      n++;
    end
    chk("req_accept", cpu_addr_ok, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aclk); #1;
      cpu_req = 1'b0;
    end
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    while ((mcount != 0 || rd_pend || ack_pend || out_busy) && n < 1000) begin
      @(negedge aclk);
      n++;
    end
    chk("drain_done", n < 1000, 1);
  endtask

  // memory responder: random address acceptance, one response per accepted request after a random latency
  initial begin
    bit hs, hs_wr, busy, busy_rd;
    int cnt;
    busy = 0; busy_rd = 0; cnt = 0;
    forever begin
      @(negedge aclk);
      hs = aresetn && mem_req && mem_addr_ok;
      hs_wr = mem_wr;
      @(posedge aclk); #1;
      mem_data_ok = 1'b0;
      mem_addr_ok = aresetn && (int'($urandom_range(99)) < p_aok);
      if (!aresetn) busy = 0;
      else begin
        if (busy) begin
          if (cnt == 0) begin
            mem_data_ok = 1'b1;
            busy = 0;
            if (busy_rd) begin
              mem_rdata = $urandom;
              rd_exp.push_back(mem_rdata);
            end
          end else cnt--;
        end
        if (hs) begin
          busy = 1;
          busy_rd = !hs_wr;
          cnt = $urandom_range(lat_hi, lat_lo);
        end
      end
    end
  end

  // scoreboard: predicts acceptance and acks from buffer occupancy, checks memory order and load data
  always @(negedge aclk) begin
    bit exp_st, exp_ld, rd_done;
    txn_t t;
    if (!aresetn) begin
      chk("rst_mem_req", mem_req, 0);
      chk("rst_cpu_addr_ok", cpu_addr_ok, 0);
      chk("rst_cpu_data_ok", cpu_data_ok, 0);
      exp_mem.delete();
      rd_exp.delete();
      mcount = 0; ack_pend = 0; rd_pend = 0; out_busy = 0; prev_wait = 0;
    end else begin
      exp_st = cpu_req && cpu_wr && mcount < DEPTH && !rd_pend;
      exp_ld = cpu_req && !cpu_wr && mcount == 0 && !rd_pend && !ack_pend && mem_addr_ok;
      rd_done = rd_pend && mem_data_ok;
      if (cpu_req) chk("cpu_addr_ok", cpu_addr_ok, exp_st || exp_ld);
      chk("cpu_data_ok", cpu_data_ok, ack_pend || rd_done);
      if (rd_done) begin
        chk("rd_data_avail", rd_exp.size() > 0, 1);
        if (rd_exp.size() > 0) chk("cpu_rdata", cpu_rdata, rd_exp.pop_front());
      end
      if (exp_st) begin
        t = '{1'b1, cpu_addr, cpu_wdata, cpu_wstrb, cpu_size};
        exp_mem.push_back(t);
      end
      if (exp_ld) begin
        t = '{1'b0, cpu_addr, 32'h0, 4'h0, cpu_size};
        exp_mem.push_back(t);
      end
      if (out_busy) chk("no_req_while_outstanding", mem_req, 0);
      if (prev_wait && mem_req) begin
        chk("mem_addr_stable", mem_addr, prev_addr);
        chk("mem_wdata_stable", mem_wdata, prev_wdata);
      end
      prev_wait = mem_req && !mem_addr_ok;
      prev_addr = mem_addr;
      prev_wdata = mem_wdata;
      if (mem_data_ok && out_busy) begin
        out_busy = 0;
        if (out_wr) mcount--;
        else rd_pend = 0;
      end
      if (mem_req && mem_addr_ok) begin
        chk("mem_txn_expected", exp_mem.size() > 0, 1);
        if (exp_mem.size() > 0) begin
          t = exp_mem.pop_front();
          chk("mem_wr", mem_wr, t.wr);
          chk("mem_addr", mem_addr, t.addr);
          chk("mem_size", mem_size, t.size);
          if (t.wr) begin
            chk("mem_wdata", mem_wdata, t.wdata);
            chk("mem_wstrb", mem_wstrb, t.wstrb);
          end
        end
        out_busy = 1;
        out_wr = mem_wr;
      end
      mcount += int'(exp_st);
      ack_pend = exp_st;
      if (exp_ld) rd_pend = 1;
    end
  end

  // directed scenarios, then a randomized mix, then reset in the middle of a drain
  initial begin
    int n;
    repeat (3) @(posedge aclk);
    #3 aresetn = 1'b1;
    req(1, 32'h1000, 32'hDEADBEEF, 4'hF, 2'd2);
    idle(1);
    wait_quiet();
    p_aok = 0;
    for (int i = 0; i < 4; i++) req(1, 32'h4000 + 32'(4 * i), $urandom, 4'hF, 2'd2);
    fork
      req(1, 32'h4010, 32'h0000_0055, 4'h3, 2'd1);
      begin
        repeat (12) @(posedge aclk);
        p_aok = 100;
      end
    join
    idle(1);
    wait_quiet();
    req(1, 32'h2000, 32'hA5A5_0001, 4'hF, 2'd2);
    req(1, 32'h2004, 32'hA5A5_0002, 4'hF, 2'd2);
    req(0, 32'h2000, 32'h0, 4'h0, 2'd2);
    idle(1);
    wait_quiet();
    lat_lo = 3; lat_hi = 3;
    req(0, 32'h3000, 32'h0, 4'h0, 2'd2);
    req(1, 32'h3004, 32'h1111_2222, 4'hC, 2'd1);
    idle(1);
    wait_quiet();
    lat_lo = 0; lat_hi = 3;
    for (int i = 0; i < 300; i++) begin
      p_aok = $urandom_range(100, 20);
      req($urandom_range(9) < 7, $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom), 2'($urandom));
      if ($urandom_range(2) == 0) idle($urandom_range(3, 1));
    end
    idle(1);
    wait_quiet();
    p_aok = 100; lat_lo = 8; lat_hi = 8;
    for (int i = 0; i < 3; i++) req(1, 32'h6000 + 32'(4 * i), $urandom, 4'hF, 2'd2);
    idle(1);
    n = 0;
    while (!out_busy && n < 100) begin
      @(negedge aclk);
      n++;
    end
    chk("drain_started", out_busy, 1);
    @(posedge aclk); #3;
    aresetn = 1'b0;
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h7000;
    repeat (3) @(negedge aclk);
    @(posedge aclk); #2;
    cpu_req = 1'b0;
    #1 aresetn = 1'b1;
    lat_lo = 0; lat_hi = 3;
    req(0, 32'h5000, 32'h0, 4'h0, 2'd2);
    idle(1);
    wait_quiet();
    chk("exp_mem_empty", exp_mem.size(), 0);
    chk("rd_exp_empty", rd_exp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
